datapath_mc: RTL and testbench



---
 rtl/datapath_mc_if.sv | 35 +++
 rtl/datapath_mc.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_datapath_mc.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_mc_if.sv
// Control, handshake and chip-side signals between the control unit and datapath_mc.
// The control unit (or a bench) takes the master side and the datapath takes the slave side.
interface datapath_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, strobe;
    logic                  CONin;
    logic                  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic                  Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]            opcode;
    logic                  IncPC;
    logic                  alu_start, alu_busy, alu_done;
    logic                  Mem_read;
    logic [DATA_WIDTH-1:0] Mem_datain, Mem_dataout;
    logic [ADDR_WIDTH-1:0] MAR_to_chip;
    logic [DATA_WIDTH-1:0] External_In, External_Out;
    logic                  con_ff_bit;

    modport master (
        output IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, strobe, CONin,
        output HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
        output Gra, Grb, Grc, Rin, Rout, BAout, opcode, IncPC, alu_start,
        output Mem_read, Mem_datain, External_In,
        input  alu_busy, alu_done, Mem_dataout, MAR_to_chip, External_Out, con_ff_bit
    );

    modport slave (
        input  IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, strobe, CONin,
        input  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
        input  Gra, Grb, Grc, Rin, Rout, BAout, opcode, IncPC, alu_start,
        input  Mem_read, Mem_datain, External_In,
        output alu_busy, alu_done, Mem_dataout, MAR_to_chip, External_Out, con_ff_bit
    );
endinterface

// File: rtl/datapath_mc.sv
// Parametrised Mini SRC bus datapath: register file, single shared bus, combinational ALU
// and a W-cycle iterative signed mul/div engine with a start/busy/done handshake.
module datapath_mc #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_SEL_BITS = 4,
    parameter int ADDR_WIDTH   = 10
) (
    input logic          clock,
    input logic          clear,
    datapath_mc_if.slave dp
);
    localparam int W         = DATA_WIDTH;
    localparam int RS        = REG_SEL_BITS;
    localparam int REG_COUNT = 2 ** RS;
    localparam int SHW       = $clog2(W);
    localparam int CW        = $clog2(W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // The opcode field is not kept: the ALU operation arrives on its own port.
    logic [W-6:0]         ir_r;
    logic [W-1:0]         regs_r [REG_COUNT];
    logic [W-1:0]         pc_r, y_r, z_hi_r, z_lo_r, hi_r, lo_r, mar_r, mdr_r, inport_r, outport_r;
    logic                 con_r, busy_r, done_r;
    logic [1:0]           state_r;
    logic [CW-1:0]        cnt_r;
    logic [W:0]           acc_r;
    logic [W-1:0]         q_r, m_r, dvd_r;
    logic                 qm1_r, is_div_r, neg_q_r, neg_r_r, dz_r;

    logic [RS-1:0]        ra_s, rb_s, rc_s, sel_s;
    logic [REG_COUNT-1:0] sel_oh_s;
    logic [1:0]           c2_s;
    logic [W-1:0]         c_ext_s, bus_s, alu_s;
    logic [SHW-1:0]       sh_s;
    logic [SHW:0]         rsh_s;
    logic                 cond_s, start_ok_s, last_s;
    logic [W:0]           booth_s, rem_sh_s, trial_s, div_acc_nx_s, acc_nx_s;
    logic [2*W+1:0]       mul_nx_s;
    logic [W-1:0]         div_q_nx_s, q_nx_s, a_abs_s, b_abs_s, res_hi_s, res_lo_s;
    logic                 qm1_nx_s;

    assign ra_s     = ir_r[W-6 -: RS];
    assign rb_s     = ir_r[W-6-RS -: RS];
    assign rc_s     = ir_r[W-6-2*RS -: RS];
    assign c2_s     = ir_r[W-12 -: 2];
    assign c_ext_s  = {{13{ir_r[W-14]}}, ir_r[W-14:0]};
    assign sel_s    = ({RS{dp.Gra}} & ra_s) | ({RS{dp.Grb}} & rb_s) | ({RS{dp.Grc}} & rc_s);
    assign sel_oh_s = REG_COUNT'(1) << sel_s;

    // Shared bus source mux, first asserted select wins.
    always_comb begin
        bus_s = '0;
        if (dp.Rout || dp.BAout) begin
            if (dp.BAout && (sel_s == '0)) begin
                bus_s = '0;
            end else begin
                bus_s = regs_r[sel_s];
            end
        end else if (dp.HIout) begin
            bus_s = hi_r;
        end else if (dp.LOout) begin
            bus_s = lo_r;
        end else if (dp.Zhi_out) begin
            bus_s = z_hi_r;
        end else if (dp.Zlo_out) begin
            bus_s = z_lo_r;
        end else if (dp.PCout) begin
            bus_s = pc_r;
        end else if (dp.MDRout) begin
            bus_s = mdr_r;
        end else if (dp.Inport_out) begin
            bus_s = inport_r;
        end else if (dp.Cout) begin
            bus_s = c_ext_s;
        end else begin
            bus_s = '0;
        end
    end

    // Single-cycle ALU with A = Y and B = bus; IncPC overrides the opcode.
    always_comb begin
        sh_s  = bus_s[SHW-1:0];
        rsh_s = (SHW+1)'(W) - {1'b0, sh_s};
        alu_s = y_r + bus_s;
        if (dp.IncPC) begin
            alu_s = bus_s + W'(1);
        end else begin
            case (dp.opcode)
                OP_SUB:          alu_s = y_r - bus_s;
                OP_AND, OP_ANDI: alu_s = y_r & bus_s;
                OP_OR, OP_ORI:   alu_s = y_r | bus_s;
                OP_SHR:          alu_s = y_r >> sh_s;
                OP_SHRA:         alu_s = W'($signed(y_r) >>> sh_s);
                OP_SHL:          alu_s = y_r << sh_s;
                OP_ROR:          alu_s = (y_r >> sh_s) | (y_r << rsh_s);
                OP_ROL:          alu_s = (y_r << sh_s) | (y_r >> rsh_s);
                OP_NEG:          alu_s = '0 - bus_s;
                OP_NOT:          alu_s = ~bus_s;
                default:         alu_s = y_r + bus_s;
            endcase
        end
    end

    // Branch condition on the bus, chosen by C2.
    always_comb begin
        case (c2_s)
            2'b00:   cond_s = (bus_s == '0);
            2'b01:   cond_s = (bus_s != '0);
            2'b10:   cond_s = ~bus_s[W-1];
            2'b11:   cond_s = bus_s[W-1];
            default: cond_s = 1'b0;
        endcase
    end

    // One engine iteration: Booth add/sub then arithmetic shift, or a restoring divide step.
    always_comb begin
        case ({q_r[0], qm1_r})
            2'b01:   booth_s = acc_r + {m_r[W-1], m_r};
            2'b10:   booth_s = acc_r - {m_r[W-1], m_r};
            default: booth_s = acc_r;
        endcase
        mul_nx_s = {booth_s[W], booth_s, q_r};
        rem_sh_s = {acc_r[W-1:0], q_r[W-1]};
        trial_s  = rem_sh_s - {1'b0, m_r};
        if (trial_s[W]) begin
            div_acc_nx_s = rem_sh_s;
            div_q_nx_s   = {q_r[W-2:0], 1'b0};
        end else begin
            div_acc_nx_s = trial_s;
            div_q_nx_s   = {q_r[W-2:0], 1'b1};
        end
        if (is_div_r) begin
            acc_nx_s = div_acc_nx_s;
            q_nx_s   = div_q_nx_s;
            qm1_nx_s = 1'b0;
        end else begin
            acc_nx_s = mul_nx_s[2*W+1:W+1];
            q_nx_s   = mul_nx_s[W:1];
            qm1_nx_s = mul_nx_s[0];
        end
    end

    // Operand magnitudes and final signed results of the engine.
    always_comb begin
        a_abs_s = y_r[W-1] ? ('0 - y_r) : y_r;
        b_abs_s = bus_s[W-1] ? ('0 - bus_s) : bus_s;
        if (!is_div_r) begin
            res_hi_s = mul_nx_s[2*W:W+1];
            res_lo_s = mul_nx_s[W:1];
        end else if (dz_r) begin
            res_hi_s = dvd_r;
            res_lo_s = '1;
        end else begin
            res_hi_s = neg_r_r ? ('0 - div_acc_nx_s[W-1:0]) : div_acc_nx_s[W-1:0];
            res_lo_s = neg_q_r ? ('0 - div_q_nx_s) : div_q_nx_s;
        end
    end

    assign start_ok_s = dp.alu_start && (state_r != ST_RUN) &&
                        ((dp.opcode == OP_MUL) || (dp.opcode == OP_DIV));
    assign last_s     = (state_r == ST_RUN) && (cnt_r == CW'(W - 1));

    // Iterative engine sequencing and operand capture.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= '0;
            q_r      <= '0;
            qm1_r    <= 1'b0;
            m_r      <= '0;
            dvd_r    <= '0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    acc_r <= acc_nx_s;
                    q_r   <= q_nx_s;
                    qm1_r <= qm1_nx_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start_ok_s) begin
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        cnt_r    <= '0;
                        acc_r    <= '0;
                        qm1_r    <= 1'b0;
                        is_div_r <= (dp.opcode == OP_DIV);
                        m_r      <= (dp.opcode == OP_DIV) ? b_abs_s : y_r;
                        q_r      <= (dp.opcode == OP_DIV) ? a_abs_s : bus_s;
                        neg_q_r  <= y_r[W-1] ^ bus_s[W-1];
                        neg_r_r  <= y_r[W-1];
                        dz_r     <= (bus_s == '0);
                        dvd_r    <= y_r;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Z register: the engine owns it while running, otherwise RZin loads the ALU.
    always_ff @(posedge clock) begin
        if (clear) begin
            z_hi_r <= '0;
            z_lo_r <= '0;
        end else if (last_s) begin
            z_hi_r <= res_hi_s;
            z_lo_r <= res_lo_s;
        end else if (dp.RZin && (state_r != ST_RUN)) begin
            z_hi_r <= '0;
            z_lo_r <= alu_s;
        end
    end

    // Architectural registers, memory interface registers and I/O ports.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= '0;
            end
            ir_r      <= '0;
            pc_r      <= '0;
            y_r       <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            mar_r     <= '0;
            mdr_r     <= '0;
            inport_r  <= '0;
            outport_r <= '0;
            con_r     <= 1'b0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (dp.Rin && sel_oh_s[i]) begin
                    regs_r[i] <= bus_s;
                end
            end
            if (dp.IRin)       ir_r      <= bus_s[W-6:0];
            if (dp.PCin)       pc_r      <= bus_s;
            if (dp.RYin)       y_r       <= bus_s;
            if (dp.HIin)       hi_r      <= bus_s;
            if (dp.LOin)       lo_r      <= bus_s;
            if (dp.MARin)      mar_r     <= bus_s;
            if (dp.MDRin)      mdr_r     <= dp.Mem_read ? dp.Mem_datain : bus_s;
            if (dp.strobe)     inport_r  <= dp.External_In;
            if (dp.Outport_in) outport_r <= bus_s;
            if (dp.CONin)      con_r     <= cond_s;
        end
    end

    assign dp.alu_busy     = busy_r;
    assign dp.alu_done     = done_r;
    assign dp.Mem_dataout  = mdr_r;
    assign dp.MAR_to_chip  = mar_r[ADDR_WIDTH-1:0];
    assign dp.External_Out = outport_r;
    assign dp.con_ff_bit   = con_r;
endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: values reach the bus through the input port and are
// observed through the output port, Mem_dataout, MAR_to_chip and the handshake flags.
module tb_datapath_mc;
    localparam int W = 32;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    logic clock = 1'b0;
    logic clear;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   s     = 0;
    int   seen  = 0;

    always #5 clock = ~clock;

    datapath_mc_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dp ();
    datapath_mc #(.DATA_WIDTH(32), .REG_SEL_BITS(4), .ADDR_WIDTH(10)) dut (
        .clock(clock), .clear(clear), .dp(dp)
    );

    logic [4:0]  ops [13] = '{5'b00000, 5'b01100, 5'b00100, 5'b00101, 5'b01110, 5'b00111, 5'b01000,
                              5'b01001, 5'b01010, 5'b01011, 5'b10001, 5'b10010, 5'b11111};
    logic [31:0] exps [13] = '{32'h80000015, 32'h80000015, 32'h8000000D, 32'h00000000, 32'h80000015,
                               32'h08000001, 32'hF8000001, 32'h00000110, 32'h18000001, 32'h00000118,
                               32'hFFFFFFFC, 32'hFFFFFFFB, 32'h80000015};

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {dp.IRin, dp.PCin, dp.RYin, dp.RZin, dp.MARin, dp.MDRin, dp.HIin, dp.LOin} = 8'b0;
        {dp.Outport_in, dp.strobe, dp.CONin, dp.IncPC, dp.alu_start, dp.Mem_read} = 6'b0;
        {dp.HIout, dp.LOout, dp.Zhi_out, dp.Zlo_out, dp.PCout, dp.MDRout, dp.Inport_out, dp.Cout} = 8'b0;
        {dp.Gra, dp.Grb, dp.Grc, dp.Rin, dp.Rout, dp.BAout} = 6'b0;
        dp.opcode = 5'b00000;
    endtask

    function automatic logic [31:0] ir_f(input int ra, input int c2);
        return (32'(ra) << 23) | (32'(c2) << 19);
    endfunction

    task automatic put_in(input logic [31:0] v);
        dp.External_In = v;
        dp.strobe = 1'b1;
        tick();
        dp.strobe = 1'b0;
    endtask

    task automatic set_ir(input logic [31:0] v);
        put_in(v);
        dp.Inport_out = 1'b1; dp.IRin = 1'b1;
        tick(); idle();
    endtask

    task automatic set_y(input logic [31:0] v);
        put_in(v);
        dp.Inport_out = 1'b1; dp.RYin = 1'b1;
        tick(); idle();
    endtask

    task automatic set_reg(input int n, input logic [31:0] v);
        set_ir(ir_f(n, 0));
        put_in(v);
        dp.Inport_out = 1'b1; dp.Gra = 1'b1; dp.Rin = 1'b1;
        tick(); idle();
    endtask

    // Caller has already asserted the bus source; latch the bus into the output port.
    task automatic see(input string tag, input logic [31:0] exp);
        dp.Outport_in = 1'b1;
        tick(); idle();
        chk(tag, dp.External_Out, exp);
    endtask

    task automatic wait_done(input string tag, input int start_cyc);
        int n = 0;
        while (dp.alu_busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(cyc - start_cyc), 32'(W));
        chk({tag, "_done"}, {31'b0, dp.alu_done}, 32'd1);
    endtask

    initial begin
        idle();
        dp.External_In = '0;
        dp.Mem_datain  = '0;
        clear = 1'b1;
        tick(); tick();
        clear = 1'b0;
        chk("rst_out", dp.External_Out, 32'h0);
        chk("rst_mdr", dp.Mem_dataout, 32'h0);
        chk("rst_mar", {22'b0, dp.MAR_to_chip}, 32'h0);
        chk("rst_flags", {29'b0, dp.con_ff_bit, dp.alu_busy, dp.alu_done}, 32'h0);

        // R5 loaded, then wiped by clear
        set_reg(5, 32'hDEADBEEF);
        set_ir(ir_f(5, 0));
        dp.Rout = 1'b1; dp.Gra = 1'b1; see("r5_load", 32'hDEADBEEF);
        clear = 1'b1; tick(); clear = 1'b0;
        set_ir(ir_f(5, 0));
        dp.Rout = 1'b1; dp.Gra = 1'b1; see("r5_clr", 32'h0);
        chk("clr_flags", {29'b0, dp.con_ff_bit, dp.alu_busy, dp.alu_done}, 32'h0);

        // mul 7 * -3 with an ignored RZin while busy
        set_y(32'd7);
        put_in(32'hFFFFFFFD);
        dp.Inport_out = 1'b1; dp.RZin = 1'b1; tick(); idle();
        dp.Inport_out = 1'b1; dp.opcode = OP_MUL; dp.alu_start = 1'b1;
        tick(); s = cyc; idle();
        chk("mul_busy", {30'b0, dp.alu_busy, dp.alu_done}, 32'h2);
        dp.PCout = 1'b1; dp.RZin = 1'b1; tick(); idle();
        dp.Zlo_out = 1'b1; see("busy_rz", 32'h4);
        wait_done("mul", s);
        tick();
        chk("mul_pulse", {31'b0, dp.alu_done}, 32'h0);
        dp.Zhi_out = 1'b1; see("mul_hi", 32'hFFFFFFFF);
        dp.Zlo_out = 1'b1; see("mul_lo", 32'hFFFFFFEB);

        // div -17 / 5
        set_y(32'hFFFFFFEF);
        put_in(32'd5);
        dp.Inport_out = 1'b1; dp.opcode = OP_DIV; dp.alu_start = 1'b1;
        tick(); s = cyc; idle();
        wait_done("div", s);
        dp.Zlo_out = 1'b1; see("div_q", 32'hFFFFFFFD);
        dp.Zhi_out = 1'b1; see("div_r", 32'hFFFFFFFE);

        // 9 / 0, then a restart accepted in the DONE cycle
        set_y(32'd9);
        dp.opcode = OP_DIV; dp.alu_start = 1'b1;
        tick(); s = cyc; idle();
        wait_done("div0", s);
        dp.opcode = OP_MUL; dp.alu_start = 1'b1;
        tick(); s = cyc; idle();
        chk("restart_busy", {31'b0, dp.alu_busy}, 32'h1);
        dp.Zlo_out = 1'b1; see("div0_q", 32'hFFFFFFFF);
        dp.Zhi_out = 1'b1; see("div0_r", 32'h9);
        wait_done("mul0", s);
        dp.Zlo_out = 1'b1; see("mul0_lo", 32'h0);

        // clear aborts a running mul
        set_y(32'd7);
        put_in(32'hFFFFFFFD);
        dp.Inport_out = 1'b1; dp.opcode = OP_MUL; dp.alu_start = 1'b1;
        tick(); idle();
        repeat (9) tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk("abort_flags", {30'b0, dp.alu_busy, dp.alu_done}, 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dp.alu_done === 1'b1) seen++;
        end
        chk("abort_nodone", 32'(seen), 32'h0);
        dp.Zlo_out = 1'b1; see("abort_zlo", 32'h0);
        dp.Zhi_out = 1'b1; see("abort_zhi", 32'h0);

        // BAout, R0 and bus priority
        set_reg(0, 32'h1234);
        set_reg(3, 32'h5555AAAA);
        set_ir(ir_f(0, 0));
        dp.BAout = 1'b1; dp.Gra = 1'b1; see("ba_r0", 32'h0);
        dp.Rout = 1'b1; dp.Gra = 1'b1; see("rout_r0", 32'h1234);
        set_ir(ir_f(3, 0));
        dp.BAout = 1'b1; dp.Gra = 1'b1; see("ba_r3", 32'h5555AAAA);
        put_in(32'h11);
        dp.Inport_out = 1'b1; dp.HIin = 1'b1; tick(); idle();
        dp.HIout = 1'b1; see("hi", 32'h11);
        dp.HIout = 1'b1; dp.Rout = 1'b1; dp.Gra = 1'b1; see("prio", 32'h5555AAAA);

        // branch condition
        set_ir(ir_f(0, 1));
        dp.CONin = 1'b1; tick(); idle();
        chk("con_nz0", {31'b0, dp.con_ff_bit}, 32'h0);
        put_in(32'h4);
        dp.Inport_out = 1'b1; dp.CONin = 1'b1; tick(); idle();
        chk("con_nz4", {31'b0, dp.con_ff_bit}, 32'h1);
        set_ir(ir_f(0, 2));
        put_in(32'h80000000);
        dp.Inport_out = 1'b1; dp.CONin = 1'b1; tick(); idle();
        chk("con_pos", {31'b0, dp.con_ff_bit}, 32'h0);
        set_ir(ir_f(0, 3));
        put_in(32'h80000000);
        dp.Inport_out = 1'b1; dp.CONin = 1'b1; tick(); idle();
        chk("con_neg", {31'b0, dp.con_ff_bit}, 32'h1);
        set_ir(ir_f(0, 0));
        put_in(32'h4);
        dp.Inport_out = 1'b1; dp.CONin = 1'b1; tick(); idle();
        chk("con_zero", {31'b0, dp.con_ff_bit}, 32'h0);

        // memory side
        dp.Mem_read = 1'b1; dp.Mem_datain = 32'hCAFE0001; dp.MDRin = 1'b1; tick(); idle();
        chk("mdr_mem", dp.Mem_dataout, 32'hCAFE0001);
        put_in(32'h7FF);
        dp.Inport_out = 1'b1; dp.MARin = 1'b1; tick(); idle();
        chk("mar", {22'b0, dp.MAR_to_chip}, 32'h3FF);
        put_in(32'h0BADF00D);
        dp.Inport_out = 1'b1; dp.MDRin = 1'b1; tick(); idle();
        chk("mdr_bus", dp.Mem_dataout, 32'h0BADF00D);
        dp.MDRout = 1'b1; see("mdr_out", 32'h0BADF00D);

        // combinational ALU table, Y = 0x80000011, B = 4
        set_y(32'h80000011);
        put_in(32'h4);
        for (int i = 0; i < 13; i++) begin
            dp.Inport_out = 1'b1; dp.opcode = ops[i]; dp.RZin = 1'b1; tick(); idle();
            dp.Zlo_out = 1'b1; see($sformatf("alu_%b", ops[i]), exps[i]);
        end
        dp.Zhi_out = 1'b1; see("alu_zhi", 32'h0);

        // IncPC and sign-extended constant
        dp.Inport_out = 1'b1; dp.PCin = 1'b1; tick(); idle();
        dp.PCout = 1'b1; dp.IncPC = 1'b1; dp.opcode = 5'b00100; dp.RZin = 1'b1; tick(); idle();
        dp.Zlo_out = 1'b1; see("incpc", 32'h5);
        set_ir(32'h00040005);
        dp.Cout = 1'b1; see("c_sext", 32'hFFFC0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
